// File: rtl/pio_pkg.sv
// Register map and shared types for the avalon_pio_gen peripheral.
// Optional input debounce is enabled by defining PIO_DEBOUNCE_EN.
package pio_pkg;

    typedef logic [2:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA_IN  = 3'd0;
    localparam pio_addr_t ADDR_DATA_OUT = 3'd1;
    localparam pio_addr_t ADDR_OUT_SET  = 3'd2;
    localparam pio_addr_t ADDR_OUT_CLR  = 3'd3;
    localparam pio_addr_t ADDR_IRQ_MASK = 3'd4;
    localparam pio_addr_t ADDR_EDGE_CAP = 3'd5;
    localparam pio_addr_t ADDR_RISE_EN  = 3'd6;
    localparam pio_addr_t ADDR_FALL_EN  = 3'd7;

    function automatic logic [31:0] width_mask(input int unsigned w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/avalon_pio_gen_if.sv
// Avalon-MM slave bus plus level interrupt for avalon_pio_gen.
import pio_pkg::*;

interface avalon_pio_gen_if;
    logic        chipselect;
    pio_addr_t   address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output chipselect, address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_in_filter.sv
// One input bit: synchroniser chain, plus debounce when PIO_DEBOUNCE_EN.
module pio_in_filter #(
    parameter int SYNC_STAGES = 2
`ifdef PIO_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 500000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filt
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pin};
    end

    assign synced = sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Filtered bit only follows once the new level has held long enough
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (synced == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= synced;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
`else
    assign filt = synced;
`endif

endmodule

// File: rtl/avalon_pio_gen.sv
// Avalon-MM PIO: output register with set/clear, filtered inputs, edge IRQ.
// Define PIO_DEBOUNCE_EN to add per-bit input debounce counters.
import pio_pkg::*;

module avalon_pio_gen #(
    parameter int                 OUT_WIDTH       = 10,
    parameter int                 IN_WIDTH        = 10,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET     = '0,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_pio_gen_if.slave      bus,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);

    localparam logic [31:0] OUT_MASK = width_mask(OUT_WIDTH);
    localparam logic [31:0] IN_MASK  = width_mask(IN_WIDTH);
    localparam logic [31:0] OUT_RST  = 32'(OUT_RESET);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        OUT_WIDTH < 1 || OUT_WIDTH > 32 ||
        IN_WIDTH < 1 || IN_WIDTH > 32) begin : g_bad_cfg
        $error("avalon_pio_gen: parameter out of range");
    end

    logic [IN_WIDTH-1:0] data_in_n;

    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
        pio_in_filter #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef PIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_filt (
            .clk   (clk),
            .reset (reset),
            .pin   (pio_in[i]),
            .filt  (data_in_n[i])
        );
    end

    // Registers are kept 32 bits wide; bits above the port widths are
    // masked on write and therefore stay constant zero.
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [31:0] irq_mask;
    logic [31:0] edge_cap;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] prev;
    logic [31:0] rdata;
    logic [31:0] rmux;
    logic [31:0] edge_det;
    logic [31:0] wd_out;
    logic [31:0] wd_in;
    logic        wr;
    logic        rd;

    assign data_in  = 32'(data_in_n);
    assign wr       = bus.chipselect & bus.write;
    assign rd       = bus.chipselect & bus.read;
    assign wd_out   = bus.writedata & OUT_MASK;
    assign wd_in    = bus.writedata & IN_MASK;
    assign edge_det = (rise_en & data_in & ~prev) |
                      (fall_en & ~data_in & prev);

    always_comb begin
        rmux = '0;
        case (bus.address)
            ADDR_DATA_IN:  rmux = data_in;
            ADDR_DATA_OUT: rmux = data_out;
            ADDR_IRQ_MASK: rmux = irq_mask;
            ADDR_EDGE_CAP: rmux = edge_cap;
            ADDR_RISE_EN:  rmux = rise_en;
            ADDR_FALL_EN:  rmux = fall_en;
            default:       rmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= OUT_RST;
            irq_mask <= '0;
            edge_cap <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            prev     <= '0;
            rdata    <= '0;
        end else begin
            prev <= data_in;
            // A fresh edge wins over a simultaneous W1C of the same bit
            if (wr && bus.address == ADDR_EDGE_CAP)
                edge_cap <= (edge_cap & ~wd_in) | edge_det;
            else
                edge_cap <= edge_cap | edge_det;
            if (wr) begin
                case (bus.address)
                    ADDR_DATA_OUT: data_out <= wd_out;
                    ADDR_OUT_SET:  data_out <= data_out | wd_out;
                    ADDR_OUT_CLR:  data_out <= data_out & ~wd_out;
                    ADDR_IRQ_MASK: irq_mask <= wd_in;
                    ADDR_RISE_EN:  rise_en  <= wd_in;
                    ADDR_FALL_EN:  fall_en  <= wd_in;
                    default: ;
                endcase
            end
            if (rd) rdata <= rmux;
        end
    end

    assign bus.readdata = rdata;
    assign bus.irq      = |(edge_cap & irq_mask);
    assign pio_out      = data_out[OUT_WIDTH-1:0];

endmodule
